// File: rtl/multdiv_issue_pkg.sv
// Shared types and constants for the multiply/divide issue block.
package multdiv_issue_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_WB    = 2'd3
    } state_e;

    localparam int          TIMEOUT_DEF   = 64;
    localparam int          CNT_W         = 7;
    localparam logic [4:0]  EXC_REG_DEF   = 5'd30;
    localparam logic [31:0] MULT_EXC_CODE = 32'd4;
    localparam logic [31:0] DIV_EXC_CODE  = 32'd5;

    function automatic logic [31:0] exc_code(input logic is_div);
        return is_div ? DIV_EXC_CODE : MULT_EXC_CODE;
    endfunction

endpackage

// File: rtl/multdiv_issue_if.sv
// Execute-stage, unit-side and writeback signals of the issue block.
// Handshake: an op transfers at a rising edge where op_valid=1 and kill=0 while the
// block is idle; stall=1 holds the front end; wb_valid is a single-cycle strobe.
interface multdiv_issue_if;
    logic        op_valid;
    logic        op_is_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  op_rd;
    logic        kill;
    logic        stall;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        md_enable;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    // master: the issue block; slave: pipeline plus multiply/divide unit around it
    modport master (
        input  op_valid, op_is_div, op_a, op_b, op_rd, kill,
        input  md_result, md_exception, md_ready,
        output stall, ctrl_MULT, ctrl_DIV, md_enable, md_operandA, md_operandB,
        output wb_valid, wb_rd, wb_data
    );

    modport slave (
        output op_valid, op_is_div, op_a, op_b, op_rd, kill,
        output md_result, md_exception, md_ready,
        input  stall, ctrl_MULT, ctrl_DIV, md_enable, md_operandA, md_operandB,
        input  wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/multdiv_issue_timeout_counter.sv
// Cycle counter with synchronous clear, count enable and terminal-count flag.
module multdiv_issue_timeout_counter #(
    parameter int W    = 7,
    parameter int TERM = 63
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         term_o
);
    localparam logic [W-1:0] TERM_V = W'(TERM);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == TERM_V);
endmodule

// File: rtl/multdiv_issue.sv
// Issues one MULT/DIV op to the multi-cycle unit, stalls until the result, then
// presents one writeback beat (result, or exception code to the status register).
module multdiv_issue
    import multdiv_issue_pkg::*;
#(
    parameter int         TIMEOUT = TIMEOUT_DEF,
    parameter logic [4:0] EXC_REG = EXC_REG_DEF
) (
    input  logic            clock,
    input  logic            resetn,
    multdiv_issue_if.master bus,
    output state_e          dbg_state
);
    state_e      state_q, state_d;
    logic [31:0] a_q, b_q, res_q;
    logic [4:0]  rd_q;
    logic        div_q, exc_q;
    logic [CNT_W-1:0] count;
    logic        term;
    logic        accept;

    assign accept = (state_q == S_IDLE) && bus.op_valid && !bus.kill;

    multdiv_issue_timeout_counter #(
        .W    (CNT_W),
        .TERM (TIMEOUT - 1)
    ) u_timeout (
        .clock   (clock),
        .resetn  (resetn),
        .clr_i   (state_q == S_START),
        .en_i    (state_q == S_BUSY),
        .count_o (count),
        .term_o  (term)
    );

    always_comb begin
        state_d       = state_q;
        bus.stall     = 1'b0;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        bus.md_enable = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        case (state_q)
            S_IDLE: begin
                bus.stall = accept;
                if (accept) state_d = S_START;
            end
            S_START: begin
                bus.stall     = 1'b1;
                bus.md_enable = 1'b1;
                bus.ctrl_MULT = !div_q;
                bus.ctrl_DIV  = div_q;
                state_d       = bus.kill ? S_IDLE : S_BUSY;
            end
            S_BUSY: begin
                bus.stall     = 1'b1;
                bus.md_enable = 1'b1;
                // ready and timeout together resolve to the real result in the capture block
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else if (bus.md_ready || term) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                bus.md_enable = 1'b1;
                bus.wb_valid  = 1'b1;
                bus.wb_rd     = exc_q ? EXC_REG : rd_q;
                bus.wb_data   = exc_q ? exc_code(div_q) : res_q;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            div_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= bus.op_a;
                b_q   <= bus.op_b;
                rd_q  <= bus.op_rd;
                div_q <= bus.op_is_div;
            end
            if (state_q == S_BUSY && !bus.kill) begin
                if (bus.md_ready) begin
                    res_q <= bus.md_result;
                    exc_q <= bus.md_exception;
                end else if (term) begin
                    res_q <= '0;
                    exc_q <= 1'b1;
                end
            end
        end
    end

    assign bus.md_operandA = a_q;
    assign bus.md_operandB = b_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_multdiv_issue.sv
// Bench for multdiv_issue: directed vector table, corner sequences and random ops
// against a behavioural unit model and an arithmetic reference model.
module tb_multdiv_issue;
  import multdiv_issue_pkg::*;

  localparam int TMO = 64;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  multdiv_issue_if mif();
  state_e dbg_state;

  multdiv_issue #(.TIMEOUT(TMO), .EXC_REG(5'd30)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (mif.master),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wb_cnt = 0;
  int mult_pulses = 0;
  int div_pulses = 0;
  int stall_cnt = 0;
  logic [31:0] cur_a = '0;
  logic [31:0] cur_b = '0;
  logic [52:0] exp_q[$];

  // ---------------- unit model ----------------
  int   unit_lat = 1;
  logic unit_exc = 1'b0;
  logic unit_ready = 1'b0;
  logic force_ready = 1'b0;
  int   ucnt = 0;
  bit   ubusy = 0;

  assign mif.md_ready = unit_ready | force_ready;

  initial begin
    mif.md_result = '0;
    mif.md_exception = 1'b0;
  end

  always @(negedge clock) begin
    if (!mif.md_enable) begin
      ubusy = 0;
      unit_ready = 1'b0;
      mif.md_exception = 1'b0;
    end else if (mif.ctrl_MULT || mif.ctrl_DIV) begin
      ubusy = 1;
      ucnt = 0;
      unit_ready = 1'b0;
      if (mif.ctrl_DIV)
        mif.md_result = (mif.md_operandB == 0) ? 32'hFFFF_FFFF :
                        32'($signed(mif.md_operandA) / $signed(mif.md_operandB));
      else
        mif.md_result = mif.md_operandA * mif.md_operandB;
    end else if (ubusy) begin
      ucnt++;
      if (ucnt == unit_lat) begin
        unit_ready = 1'b1;
        mif.md_exception = unit_exc;
        ubusy = 0;
      end else begin
        unit_ready = 1'b0;
      end
    end else begin
      unit_ready = 1'b0;
      mif.md_exception = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [52:0] e, got;
    cyc++;
    if (mif.stall) stall_cnt++;
    if (mif.ctrl_MULT) mult_pulses++;
    if (mif.ctrl_DIV) div_pulses++;
    if (mif.md_enable) begin
      checks++;
      if (mif.md_operandA !== cur_a || mif.md_operandB !== cur_b) begin
        errors++;
        $display("FAIL operands: got %h/%h expected %h/%h", mif.md_operandA, mif.md_operandB, cur_a, cur_b);
      end
    end
    if (mif.wb_valid) begin
      wb_cnt++;
      checks++;
      got = {mif.wb_rd, mif.wb_data, 16'(cyc)};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wb: got rd=%0d data=%h with nothing expected", mif.wb_rd, mif.wb_data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL writeback: got rd=%0d data=%h cyc=%0d expected rd=%0d data=%h cyc=%0d",
                   got[52:48], got[47:16], got[15:0], e[52:48], e[47:16], e[15:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [140:0] outs;
    outs = {mif.stall, mif.ctrl_MULT, mif.ctrl_DIV, mif.md_enable, mif.md_operandA,
            mif.md_operandB, mif.wb_valid, mif.wb_rd, mif.wb_data, dbg_state};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL %s: outputs not all zero, got %h", name, outs);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                                    input logic div, input int lat, input logic exc,
                                    output logic [4:0] e_rd, output logic [31:0] e_data, output int e_lat);
    if (lat > TMO) begin
      e_rd = 5'd30;
      e_data = div ? 32'd5 : 32'd4;
      e_lat = TMO;
    end else if (exc) begin
      e_rd = 5'd30;
      e_data = div ? 32'd5 : 32'd4;
      e_lat = lat;
    end else begin
      e_rd = rd;
      e_data = div ? 32'($signed(a) / $signed(b)) : a * b;
      e_lat = lat;
    end
  endfunction

  // mode 0: complete normally; 1: kill at BUSY cycle ev_at; 2: reset at BUSY cycle ev_at
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic div, input int lat, input logic exc,
                        input logic [4:0] e_rd, input logic [31:0] e_data, input int e_lat,
                        input int mode, input int ev_at);
    int m0, d0, s0, w0, c0;
    bit done;
    @(posedge clock); #2;
    mif.op_valid = 1'b1; mif.op_a = a; mif.op_b = b; mif.op_rd = rd; mif.op_is_div = div;
    mif.kill = 1'b0;
    unit_lat = lat; unit_exc = exc; cur_a = a; cur_b = b;
    m0 = mult_pulses; d0 = div_pulses; s0 = stall_cnt; w0 = wb_cnt;
    @(negedge clock); #1;
    c0 = cyc;
    if (mode == 0) exp_q.push_back({e_rd, e_data, 16'(c0 + e_lat + 2)});
    @(posedge clock); #2;
    mif.op_valid = 1'b0;
    mif.op_a = $urandom; mif.op_b = $urandom; mif.op_rd = 5'($urandom); mif.op_is_div = ~div;
    if (mode == 0) begin
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
        @(negedge clock); #1;
        if (wb_cnt != w0) done = 1;
      end
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL wb_wait: got no wb_valid within 200 cycles, expected one");
      end
      check("mult_pulses", 64'(mult_pulses - m0), div ? 64'd0 : 64'd1);
      check("div_pulses", 64'(div_pulses - d0), div ? 64'd1 : 64'd0);
      check("stall_cycles", 64'(stall_cnt - s0), 64'(e_lat + 2));
    end else begin
      repeat (ev_at) @(posedge clock);
      #2;
      if (mode == 1) begin
        mif.kill = 1'b1;
        @(posedge clock); #2;
        mif.kill = 1'b0;
        #1;
        check("kill_state", 64'(dbg_state), 64'(S_IDLE));
        check("kill_md_enable", 64'(mif.md_enable), 64'd0);
        check("kill_stall", 64'(mif.stall), 64'd0);
        @(posedge clock); #2;
        force_ready = 1'b1;
        @(posedge clock); #2;
        force_ready = 1'b0;
      end else begin
        resetn = 1'b0;
        #1;
        check_all_zero("reset_mid_op");
        repeat (2) @(posedge clock);
        #2;
        check_all_zero("reset_held");
        resetn = 1'b1;
      end
      repeat (4) @(posedge clock);
      #2;
      check("no_wb_after_abort", 64'(wb_cnt - w0), 64'd0);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        div;
    int          lat;
    logic        exc;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    int          e_lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  r_rd;
    logic [31:0] r_data;
    int          r_lat;

    mif.op_valid = 1'b0; mif.op_is_div = 1'b0; mif.op_a = '0; mif.op_b = '0;
    mif.op_rd = '0; mif.kill = 1'b0;

    vecs[0] = '{32'd7,          32'hFFFF_FFFD, 5'd5, 1'b0, 16,   1'b0, 5'd5,  32'hFFFF_FFEB, 16};
    vecs[1] = '{32'd100,        32'd0,         5'd9, 1'b1, 8,    1'b1, 5'd30, 32'd5,         8};
    vecs[2] = '{32'd3,          32'd4,         5'd7, 1'b0, 1000, 1'b0, 5'd30, 32'd4,         64};
    vecs[3] = '{32'd6,          32'd7,         5'd3, 1'b0, 5,    1'b0, 5'd3,  32'd42,        5};
    vecs[4] = '{32'hFFFF_FFEC,  32'd4,         5'd4, 1'b1, 9,    1'b0, 5'd4,  32'hFFFF_FFFB, 9};
    vecs[5] = '{32'd9,          32'd9,         5'd1, 1'b0, 64,   1'b0, 5'd1,  32'd81,        64};
    vecs[6] = '{32'd9,          32'd9,         5'd1, 1'b1, 1000, 1'b0, 5'd30, 32'd5,         64};
    vecs[7] = '{32'd2,          32'd3,         5'd0, 1'b0, 3,    1'b0, 5'd0,  32'd6,         3};
    vecs[8] = '{32'd5,          32'd5,         5'd2, 1'b1, 1,    1'b0, 5'd2,  32'd1,         1};

    #3;
    check_all_zero("reset_state");
    #9;
    resetn = 1'b1;

    // kill together with op_valid in IDLE: not accepted
    @(posedge clock); #2;
    mif.op_valid = 1'b1; mif.op_a = 32'd11; mif.op_b = 32'd12; mif.op_rd = 5'd6; mif.kill = 1'b1;
    #1;
    check("idle_kill_stall", 64'(mif.stall), 64'd0);
    @(posedge clock); #2;
    mif.op_valid = 1'b0; mif.kill = 1'b0;
    #1;
    check("idle_kill_state", 64'(dbg_state), 64'(S_IDLE));
    check("idle_kill_md_enable", 64'(mif.md_enable), 64'd0);

    // directed table, issued back-to-back
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].div, vecs[i].lat, vecs[i].exc,
             vecs[i].e_rd, vecs[i].e_data, vecs[i].e_lat, 0, 0);

    // kill in BUSY cycle 10, late ready must not write back
    run_op(32'd100, 32'd7, 5'd8, 1'b1, 20, 1'b0, 5'd0, 32'd0, 0, 1, 10);
    // kill in START
    run_op(32'd4, 32'd4, 5'd8, 1'b0, 5, 1'b0, 5'd0, 32'd0, 0, 1, 0);
    // reset during BUSY, then a normal op
    run_op(32'd13, 32'd3, 5'd10, 1'b0, 30, 1'b0, 5'd0, 32'd0, 0, 2, 6);
    run_op(32'd13, 32'd3, 5'd10, 1'b0, 4, 1'b0, 5'd10, 32'd39, 4, 0, 0);

    // randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      logic        rdiv, rexc;
      logic [4:0]  rrd;
      int          rlat;
      ra = 32'($signed(16'($urandom)));
      rb = 32'($signed(16'($urandom)));
      rdiv = 1'($urandom_range(0, 1));
      rrd = 5'($urandom_range(0, 31));
      rlat = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(1, 20);
      rexc = ($urandom_range(0, 9) == 0);
      if (rdiv && rb == 0) rexc = 1'b1;
      ref_model(ra, rb, rrd, rdiv, rlat, rexc, r_rd, r_data, r_lat);
      run_op(ra, rb, rrd, rdiv, rlat, rexc, r_rd, r_data, r_lat, 0, 0);
    end

    repeat (3) @(posedge clock);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
